// File: rtl/mdu_unit_if.sv
// EX-stage multiply/divide unit bus: op/move controls and operands in, busy and HI/LO read data out.
// master = pipeline side, slave = the MDU.
interface mdu_unit_if;
  logic [3:0]  MDUOpE;
  logic [1:0]  MTHILOE;
  logic [1:0]  MFHILOE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        MDUCLR;
  logic        MDUBusyE;
  logic [31:0] MDUResultE;

  modport master (
    output MDUOpE, MTHILOE, MFHILOE, SrcAE, SrcBE, MDUCLR,
    input  MDUBusyE, MDUResultE
  );

  modport slave (
    input  MDUOpE, MTHILOE, MFHILOE, SrcAE, SrcBE, MDUCLR,
    output MDUBusyE, MDUResultE
  );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle MUL/DIV/MADD/MSUB unit with HI/LO: result computed at start, committed after N busy cycles.
// MDUBusyE stalls the pipeline from the start cycle through the commit cycle; MDUCLR aborts without commit.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic       clk,
  input  logic       reset,
  mdu_unit_if.slave  bus
);

  localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = ($clog2(MAX_CYC) < 4) ? 4 : $clog2(MAX_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      hi_q, lo_q;
  logic [3:0]       op_reg;
  logic [63:0]      res_reg;
  logic             div_zero_q;

  logic is_mdu_op, is_div_op, start, commit;

  assign is_mdu_op = (bus.MDUOpE[3] == 1'b0);
  assign is_div_op = (bus.MDUOpE[3:1] == 3'b001);
  assign start     = (state_q == ST_IDLE) && is_mdu_op && !bus.MDUCLR;
  assign commit    = (state_q != ST_IDLE) && !bus.MDUCLR && (cnt_q == '0);

  // Operand conditioning: even op codes are the signed variants.
  logic        signed_op, a_neg, b_neg, b_zero;
  logic [63:0] a_ext, b_ext, product;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  always_comb begin
    signed_op = ~bus.MDUOpE[0];
    a_neg     = signed_op & bus.SrcAE[31];
    b_neg     = signed_op & bus.SrcBE[31];
    b_zero    = (bus.SrcBE == 32'd0);
    a_ext     = {{32{a_neg}}, bus.SrcAE};
    b_ext     = {{32{b_neg}}, bus.SrcBE};
    product   = a_ext * b_ext;
    a_mag     = a_neg ? -bus.SrcAE : bus.SrcAE;
    b_mag     = b_neg ? -bus.SrcBE : bus.SrcBE;
    q_mag     = b_zero ? 32'd0 : a_mag / b_mag;
    r_mag     = b_zero ? 32'd0 : a_mag % b_mag;
    // Truncating division: quotient sign from both operands, remainder follows the dividend.
    quot      = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem       = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = is_div_op ? ST_DIV : ST_MUL;
        end
      end
      default: begin
        if (bus.MDUCLR || (cnt_q == '0)) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    bus.MDUBusyE = start || (state_q != ST_IDLE);
    case (bus.MFHILOE)
      2'b01:   bus.MDUResultE = hi_q;
      2'b10:   bus.MDUResultE = lo_q;
      default: bus.MDUResultE = 32'd0;
    endcase
  end

  logic [63:0] hilo, hilo_add, hilo_sub;
  assign hilo     = {hi_q, lo_q};
  assign hilo_add = hilo + res_reg;
  assign hilo_sub = hilo - res_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      op_reg     <= 4'hF;
      res_reg    <= 64'd0;
      div_zero_q <= 1'b0;
    end else begin
      if (start) begin
        op_reg     <= bus.MDUOpE;
        res_reg    <= is_div_op ? {rem, quot} : product;
        div_zero_q <= is_div_op & b_zero;
        cnt_q      <= is_div_op ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
      end else if (state_q != ST_IDLE) begin
        cnt_q <= (bus.MDUCLR || (cnt_q == '0)) ? '0 : cnt_q - 1'b1;
      end

      if (commit) begin
        case (op_reg)
          4'h0, 4'h1: {hi_q, lo_q} <= res_reg;
          4'h2, 4'h3: begin
            // A zero divisor still costs the full busy time but leaves HI/LO alone.
            if (!div_zero_q) begin
              {hi_q, lo_q} <= res_reg;
            end
          end
          4'h4, 4'h5: {hi_q, lo_q} <= hilo_add;
          4'h6, 4'h7: {hi_q, lo_q} <= hilo_sub;
          default: ;
        endcase
      end else if ((state_q == ST_IDLE) && !start) begin
        case (bus.MTHILOE)
          2'b00:   hi_q <= bus.SrcAE;
          2'b01:   lo_q <= bus.SrcAE;
          default: ;
        endcase
      end
    end
  end

  // The hazard unit must hold new MDU ops in ID while the unit is busy.
  a_no_op_while_busy: assert property (@(posedge clk) disable iff (reset)
    !((state_q != ST_IDLE) && is_mdu_op));

endmodule

// File: tb/tb_mdu_unit.sv
// Directed test of mdu_unit: busy timing, HI/LO results for each op class, cancel and reset behaviour.
module tb_mdu_unit;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mdu_unit_if m ();

  mdu_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] OP_MULT  = 4'h0;
  localparam logic [3:0] OP_MULTU = 4'h1;
  localparam logic [3:0] OP_DIV   = 4'h2;
  localparam logic [3:0] OP_DIVU  = 4'h3;
  localparam logic [3:0] OP_MADDU = 4'h5;
  localparam logic [3:0] OP_MSUB  = 4'h6;
  localparam logic [3:0] OP_NONE  = 4'hF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents an op for one cycle and counts the cycles MDUBusyE stays high, start cycle included.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    cycles   = 0;
    m.MDUOpE = op;
    m.SrcAE  = a;
    m.SrcBE  = b;
    #1;
    while (m.MDUBusyE && cycles < 100) begin
      cycles++;
      next_cycle();
      m.MDUOpE = OP_NONE;
      #1;
    end
    m.MDUOpE = OP_NONE;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    m.MFHILOE = 2'b01;
    #1;
    hi = m.MDUResultE;
    m.MFHILOE = 2'b10;
    #1;
    lo = m.MDUResultE;
    m.MFHILOE = 2'b00;
  endtask

  task automatic move_to(input logic [1:0] sel, input logic [31:0] val);
    m.MTHILOE = sel;
    m.SrcAE   = val;
    next_cycle();
    m.MTHILOE = 2'b10;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic [31:0] hi, lo;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    m.MDUOpE  = OP_NONE;
    m.MTHILOE = 2'b10;
    m.MFHILOE = 2'b00;
    m.SrcAE   = 32'd0;
    m.SrcBE   = 32'd0;
    m.MDUCLR  = 1'b0;

    #2;
    check("reset_busy", {31'd0, m.MDUBusyE}, 32'd0);
    check("reset_result", m.MDUResultE, 32'd0);
    read_hilo(hi, lo);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // First op right at the first edge after reset is released.
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_cycles", 32'(cyc), 32'd6);
    read_hilo(hi, lo);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_cycles", 32'(cyc), 32'd11);
    read_hilo(hi, lo);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_cycles", 32'(cyc), 32'd6);
    read_hilo(hi, lo);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(OP_DIVU, 32'hFFFF_FFF9, 32'd2, cyc);
    read_hilo(hi, lo);
    check("divu_hi", hi, 32'h0000_0001);
    check("divu_lo", lo, 32'h7FFF_FFFC);

    move_to(2'b00, 32'd0);
    move_to(2'b01, 32'hFFFF_FFFF);
    read_hilo(hi, lo);
    check("mthi_hi", hi, 32'd0);
    check("mtlo_lo", lo, 32'hFFFF_FFFF);
    issue(OP_MADDU, 32'd1, 32'd1, cyc);
    check("maddu_cycles", 32'(cyc), 32'd6);
    read_hilo(hi, lo);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);

    // {1,0} - 6 borrows out of LO.
    issue(OP_MSUB, 32'd2, 32'd3, cyc);
    read_hilo(hi, lo);
    check("msub_hi", hi, 32'd0);
    check("msub_lo", lo, 32'hFFFF_FFFA);

    move_to(2'b00, 32'd5);
    move_to(2'b01, 32'd6);
    issue(OP_DIVU, 32'd9, 32'd0, cyc);
    check("divz_cycles", 32'(cyc), 32'd11);
    read_hilo(hi, lo);
    check("divz_hi", hi, 32'd5);
    check("divz_lo", lo, 32'd6);

    // Cancel the DIVU one cycle after it starts.
    m.MDUOpE = OP_DIVU;
    m.SrcAE  = 32'd100;
    m.SrcBE  = 32'd7;
    #1;
    check("cancel_start_busy", {31'd0, m.MDUBusyE}, 32'd1);
    next_cycle();
    m.MDUOpE = OP_NONE;
    m.MDUCLR = 1'b1;
    #1;
    check("cancel_cycle_busy", {31'd0, m.MDUBusyE}, 32'd1);
    next_cycle();
    m.MDUCLR = 1'b0;
    #1;
    check("cancel_after_busy", {31'd0, m.MDUBusyE}, 32'd0);
    read_hilo(hi, lo);
    check("cancel_hi", hi, 32'd5);
    check("cancel_lo", lo, 32'd6);

    // MDUCLR while idle suppresses the start.
    m.MDUOpE = OP_MULT;
    m.MDUCLR = 1'b1;
    #1;
    check("clr_idle_busy", {31'd0, m.MDUBusyE}, 32'd0);
    next_cycle();
    m.MDUOpE = OP_NONE;
    m.MDUCLR = 1'b0;
    #1;
    check("clr_idle_after", {31'd0, m.MDUBusyE}, 32'd0);

    // MTHI in the same cycle as a start is dropped.
    m.MTHILOE = 2'b00;
    issue(OP_MULT, 32'd3, 32'd4, cyc);
    m.MTHILOE = 2'b10;
    read_hilo(hi, lo);
    check("mthi_start_hi", hi, 32'd0);
    check("mthi_start_lo", lo, 32'd12);

    read_hilo(hi, lo);
    m.MFHILOE = 2'b11;
    #1;
    check("mfhilo_11", m.MDUResultE, 32'd0);
    m.MFHILOE = 2'b00;

    // Reset asserted in the third busy cycle of a MULT.
    m.MDUOpE = OP_MULT;
    m.SrcAE  = 32'd5;
    m.SrcBE  = 32'd5;
    next_cycle();
    m.MDUOpE = OP_NONE;
    next_cycle();
    #1;
    check("rst_mid_pre_busy", {31'd0, m.MDUBusyE}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", {31'd0, m.MDUBusyE}, 32'd0);
    read_hilo(hi, lo);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    next_cycle();
    reset = 1'b0;
    issue(OP_MULT, 32'd7, 32'd6, cyc);
    check("post_rst_cycles", 32'(cyc), 32'd6);
    read_hilo(hi, lo);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd42);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 Parameter MUL_CYCLES, 5, number of busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
REQ-002 Parameter DIV_CYCLES, 10, number of busy cycles for DIV/DIVU.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 MDUOpE  input  4  EX-stage op: 0000 MULT, 0001 MULTU, 0010 DIV, 0011 DIVU, 0100 MADD, 0101 MADDU, 0110 MSUB, 0111 MSUBU, 1111 MDU_DUM (none); other codes are treated as none.
REQ-006 MTHILOE  input  2  EX-stage move-to: 00 MTHI, 01 MTLO, 10 none, 11 none.
REQ-007 MFHILOE  input  2  EX-stage move-from: 00 none, 01 MFHI, 10 MFLO, 11 none.
REQ-008 SrcAE  input  32  forwarded rs operand.
REQ-009 SrcBE  input  32  forwarded rt operand.
REQ-010 MDUCLR  input  1  cancel: abort the op issued in the previous cycle (exception on it in MEM).
REQ-011 MDUBusyE  output  1  unit busy, consumed by the hazard unit.
REQ-012 MDUResultE  output  32  HI or LO value for MFHI/MFLO.

Function
REQ-013 States: IDLE, MUL, DIV; a down-counter cnt (4 bits minimum) and registers HI, LO, opReg, resReg[63:0].
REQ-014 Start = (state==IDLE) && op code 0000-0111 && !MDUCLR.
REQ-015 MDUBusyE = Start || (state!=IDLE), combinational, so an MDU op in ID during a Start cycle is stalled.
REQ-016 On Start edge: MUL ops -> state MUL, cnt=MUL_CYCLES-1; DIV ops -> state DIV, cnt=DIV_CYCLES-1; opReg latches the code.
REQ-017 On Start edge: resReg latches SrcAE*SrcBE (MULT/MADD/MSUB signed, MULTU/MADDU/MSUBU unsigned, 64-bit product).
REQ-018 On Start edge for DIV/DIVU: resReg = {remainder, quotient} (signed for DIV, unsigned for DIVU; remainder takes the dividend's sign).
REQ-019 Divisor zero: the full DIV_CYCLES busy time elapses; HI/LO are left unchanged at completion.
REQ-020 Each busy cycle with cnt!=0 decrements cnt.
REQ-021 Busy cycle with cnt==0: commit, return to IDLE.
REQ-022 Commit for MULT/MULTU/DIV/DIVU: {HI,LO} = resReg.
REQ-023 Commit for MADD/MADDU: {HI,LO} = {HI,LO} + resReg, mod 2^64.
REQ-024 Commit for MSUB/MSUBU: {HI,LO} = {HI,LO} - resReg, mod 2^64.
REQ-025 Total latency: op in EX in cycle T -> MDUBusyE high in cycles T..T+N -> HI/LO updated at the end of cycle T+N (N=MUL_CYCLES or DIV_CYCLES) -> MDUBusyE low in cycle T+N+1.
REQ-026 MDUCLR while state!=IDLE: next edge returns to IDLE, no commit, HI/LO keep pre-op values.
REQ-027 MDUCLR while IDLE: no effect except suppressing Start.
REQ-028 MDUCLR never undoes MTHI/MTLO.
REQ-029 MTHI/MTLO: HI or LO = SrcAE at the edge, only when state==IDLE and no Start in the same cycle.
REQ-030 MTHI/MTLO while busy is ignored; the hazard unit prevents it.
REQ-031 MDUResultE = HI when MFHILOE==01, LO when 10, else 0; combinational from current registers.
REQ-032 An MDU op presented while state!=IDLE is ignored; a simulation assertion flags it.

Reset
REQ-033 reset asserted, including mid-operation, immediately forces: state=IDLE, cnt=0, HI=0, LO=0, resReg=0, opReg=1111.
REQ-034 During reset: MDUBusyE=0 if no op presented, MDUResultE=0.
REQ-035 First Start is possible at the first edge after reset deasserts.

Verification
REQ-036 MULT with A=0xFFFFFFFE (-2), B=3 -> busy 6 cycles incl. start; HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 DIV with A=-7, B=2 -> busy 11 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-038 Setup MTHI 0 and MTLO 0xFFFFFFFF, then MADDU A=1, B=1 -> HI=1, LO=0.
REQ-039 DIVU started, MDUCLR=1 the next cycle -> busy drops the following cycle; HI/LO unchanged.
REQ-040 MULT started, reset pulsed at busy cycle 3 -> MDUBusyE=0, HI=LO=0 immediately.
REQ-041 DIVU by zero with HI=5, LO=6 -> 11 busy cycles; MFHI then returns 5 and MFLO returns 6.
